// File: rtl/pulse_window_sched.sv
// Trigger-timestamping window scheduler: queues trigger times and plays one delayed gate window per trigger.
// Optional define PULSE_WIN_SCHED_MERGE_EN merges overlapping queued windows into the active one.
module pulse_window_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trig_in,
  input  logic [CW-1:0]           cfg_delay,
  input  logic [CW-1:0]           cfg_width,
  input  logic                    cfg_wr,
  output logic                    cfg_ack,
  output logic                    win_out,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  pend_cnt,
  output logic                    ovf_err,
  output logic                    late_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic            trig_prev_q;
  logic [CW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic [CW-1:0]   ts_q, ts_d, dly_q, dly_d, wid_q, wid_d, end_q, end_d, end_n;
  logic [CW-1:0]   act_dly_q, act_dly_d, act_wid_q, act_wid_d;
  logic [CW-1:0]   shd_dly_q, shd_dly_d, shd_wid_q, shd_wid_d;
  logic            shd_pend_q, shd_pend_d;
  logic            win_q, win_d, ack_q, ack_d, busy_q, busy_d;
  logic            ovf_q, ovf_d, late_q, late_d;

  logic            push, pop, full, push_ok, apply;
  logic [CW-1:0]   head, elapsed, start_thr;

  assign push      = trig_in & ~trig_prev_q;
  assign full      = (count_q == NW'(DEPTH));
  assign push_ok   = push & (~full | pop);
  assign head      = mem_q[rd_ptr_q];
  assign elapsed   = tcnt_q - ts_q;
  assign start_thr = CW'(2) + dly_q;
  assign apply     = (state_q == S_IDLE) && (count_q == '0) && shd_pend_q;

`ifdef PULSE_WIN_SCHED_MERGE_EN
  // Head window in timestamp terms; room/grow are modular differences whose MSB marks "negative".
  logic [CW-1:0]   head_nom, head_end, room, grow;
  assign head_nom = head + CW'(3) + act_dly_q;
  assign head_end = head_nom + act_wid_q - CW'(1);
  assign room     = end_q + CW'(1) - head_nom;
  assign grow     = head_end - end_q;
`endif

  // Window engine next-state
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ts_d    = ts_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    end_n   = end_q;
    end_d   = end_q;
    win_d   = 1'b0;
    late_d  = late_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          ts_d    = head;
          dly_d   = act_dly_q;
          wid_d   = act_wid_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // elapsed+1 is the cycle the window would start; nominal start is ts+3+delay
        if (elapsed >= start_thr) begin
          state_d = S_ACTIVE;
          win_d   = 1'b1;
          end_d   = tcnt_q + wid_q;
          if (elapsed > start_thr) late_d = 1'b1;
        end
      end
      S_ACTIVE: begin
`ifdef PULSE_WIN_SCHED_MERGE_EN
        if ((count_q != '0) && !room[CW-1]) begin
          pop = 1'b1;
          if (!grow[CW-1]) end_n = head_end;
        end
`endif
        end_d = end_n;
        if (tcnt_q == end_n) begin
          state_d = S_IDLE;
        end else begin
          win_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping, config shadow and status flags
  always_comb begin
    tcnt_d     = tcnt_q + CW'(1);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + NW'(push_ok) - NW'(pop);
    ovf_d      = ovf_q | (push & full & ~pop);
    shd_dly_d  = shd_dly_q;
    shd_wid_d  = shd_wid_q;
    shd_pend_d = shd_pend_q;
    act_dly_d  = act_dly_q;
    act_wid_d  = act_wid_q;
    ack_d      = 1'b0;
    if (apply) begin
      act_dly_d  = shd_dly_q;
      act_wid_d  = shd_wid_q;
      shd_pend_d = 1'b0;
      ack_d      = 1'b1;
    end
    // A write landing on the apply cycle stays pending for the next idle window
    if (cfg_wr) begin
      shd_dly_d  = cfg_delay;
      shd_wid_d  = (cfg_width == '0) ? CW'(1) : cfg_width;
      shd_pend_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= tcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      trig_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ts_q        <= '0;
      dly_q       <= '0;
      wid_q       <= CW'(1);
      end_q       <= '0;
      act_dly_q   <= '0;
      act_wid_q   <= CW'(1);
      shd_dly_q   <= '0;
      shd_wid_q   <= CW'(1);
      shd_pend_q  <= 1'b0;
      win_q       <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      trig_prev_q <= trig_in;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ts_q        <= ts_d;
      dly_q       <= dly_d;
      wid_q       <= wid_d;
      end_q       <= end_d;
      act_dly_q   <= act_dly_d;
      act_wid_q   <= act_wid_d;
      shd_dly_q   <= shd_dly_d;
      shd_wid_q   <= shd_wid_d;
      shd_pend_q  <= shd_pend_d;
      win_q       <= win_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      late_q      <= late_d;
    end
  end

  assign cfg_ack  = ack_q;
  assign win_out  = win_q;
  assign busy     = busy_q;
  assign pend_cnt = count_q;
  assign ovf_err  = ovf_q;
  assign late_err = late_q;

endmodule

// File: tb/tb_pulse_window_sched.sv
// Directed bench for pulse_window_sched: single-trigger vector table plus multi-cycle corner sequences.
module tb_pulse_window_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 32;
  localparam int          MAXC  = 256;

  logic          clk;
  logic          rst;
  logic          trig_in;
  logic [CW-1:0] cfg_delay;
  logic [CW-1:0] cfg_width;
  logic          cfg_wr;
  logic          cfg_ack;
  logic          win_out;
  logic          busy;
  logic [2:0]    pend_cnt;
  logic          ovf_err;
  logic          late_err;

  pulse_window_sched #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_wr(cfg_wr),
    .cfg_ack(cfg_ack), .win_out(win_out), .busy(busy), .pend_cnt(pend_cnt),
    .ovf_err(ovf_err), .late_err(late_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Input waves indexed by relative cycle; histories hold outputs seen in each cycle
  bit trig_w [MAXC];
  bit wr_w   [MAXC];
  bit rst_w  [MAXC];
  bit win_h  [MAXC];
  bit ack_h  [MAXC];
  bit busy_h [MAXC];
  bit ovf_h  [MAXC];
  bit late_h [MAXC];
  int pend_h [MAXC];

  typedef struct {
    int dly;
    int wid;
    int hold;
    int exp_start;
    int exp_len;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_waves();
    for (int i = 0; i < MAXC; i++) begin
      trig_w[i] = 1'b0;
      wr_w[i]   = 1'b0;
      rst_w[i]  = 1'b0;
    end
  endtask

  task automatic record(input int idx);
    win_h[idx]  = win_out;
    ack_h[idx]  = cfg_ack;
    busy_h[idx] = busy;
    ovf_h[idx]  = ovf_err;
    late_h[idx] = late_err;
    pend_h[idx] = int'(pend_cnt);
  endtask

  task automatic run(input int n);
    record(0);
    for (int c = 0; c < n; c++) begin
      trig_in = trig_w[c];
      cfg_wr  = wr_w[c];
      rst     = rst_w[c];
      tick();
      record(c + 1);
    end
    trig_in = 1'b0;
    cfg_wr  = 1'b0;
    rst     = 1'b0;
  endtask

  function automatic int count_high(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (win_h[i]) n++;
    return n;
  endfunction

  function automatic int first_high();
    for (int i = 0; i < MAXC; i++) if (win_h[i]) return i;
    return -1;
  endfunction

  function automatic int last_high(input int hi);
    int l = -1;
    for (int i = 0; i <= hi; i++) if (win_h[i]) l = i;
    return l;
  endfunction

  function automatic int count_ack(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (ack_h[i]) n++;
    return n;
  endfunction

  function automatic int max_pend(input int hi);
    int m = 0;
    for (int i = 0; i <= hi; i++) if (pend_h[i] > m) m = pend_h[i];
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Write config at relative cycle 0 on an idle engine; ack is expected in cycle 2
  task automatic set_cfg(input int d, input int w, input string tag);
    cfg_delay = CW'(d);
    cfg_width = CW'(w);
    clear_waves();
    wr_w[0] = 1'b1;
    run(6);
    check({tag, " cfg_ack count"}, count_ack(0, 6), 1);
    check({tag, " cfg_ack cycle"}, int'(ack_h[2]), 1);
  endtask

  initial begin
    vt[0] = '{dly: 10, wid: 5,  hold: 1,  exp_start: 13, exp_len: 5};
    vt[1] = '{dly: 0,  wid: 4,  hold: 20, exp_start: 3,  exp_len: 4};
    vt[2] = '{dly: 0,  wid: 1,  hold: 1,  exp_start: 3,  exp_len: 1};
    vt[3] = '{dly: 0,  wid: 0,  hold: 1,  exp_start: 3,  exp_len: 1};
    vt[4] = '{dly: 7,  wid: 3,  hold: 2,  exp_start: 10, exp_len: 3};
    vt[5] = '{dly: 2,  wid: 12, hold: 1,  exp_start: 5,  exp_len: 12};

    rst = 1'b1; trig_in = 1'b0; cfg_wr = 1'b0; cfg_delay = '0; cfg_width = '0;
    tick();
    tick();
    check("reset win_out",  int'(win_out),  0);
    check("reset cfg_ack",  int'(cfg_ack),  0);
    check("reset busy",     int'(busy),     0);
    check("reset pend_cnt", int'(pend_cnt), 0);
    check("reset ovf_err",  int'(ovf_err),  0);
    check("reset late_err", int'(late_err), 0);
    rst = 1'b0;
    tick();

    // Single trigger on an idle engine
    for (int i = 0; i < 6; i++) begin
      string tg;
      int    e;
      tg = $sformatf("vec%0d", i);
      e  = vt[i].exp_start + vt[i].exp_len;
      do_reset();
      set_cfg(vt[i].dly, vt[i].wid, tg);
      clear_waves();
      for (int k = 0; k < vt[i].hold; k++) trig_w[k] = 1'b1;
      run(60);
      check({tg, " start"},       first_high(),         vt[i].exp_start);
      check({tg, " high count"},  count_high(0, 60),    vt[i].exp_len);
      check({tg, " last high"},   int'(win_h[e - 1]),   1);
      check({tg, " pend after push"}, pend_h[1],        1);
      check({tg, " pend after pop"},  pend_h[2],        0);
      check({tg, " busy early"},  int'(busy_h[1]),      1);
      check({tg, " busy after"},  int'(busy_h[e]),      0);
      check({tg, " ovf_err"},     int'(ovf_h[60]),      0);
      check({tg, " late_err"},    int'(late_h[60]),     0);
    end

    // Overflow: six edges two cycles apart into a 4-deep queue
    do_reset();
    set_cfg(50, 4, "ovf");
    clear_waves();
    for (int k = 0; k < 6; k++) trig_w[2 * k] = 1'b1;
    run(100);
    check("ovf ovf_err",   int'(ovf_h[100]), 1);
    check("ovf pend peak", max_pend(100),    4);
    check("ovf start",     first_high(),     53);
`ifdef PULSE_WIN_SCHED_MERGE_EN
    check("ovf high count", count_high(0, 100), 12);
    check("ovf last high",  last_high(100),     64);
    check("ovf late_err",   int'(late_h[100]),  0);
`else
    check("ovf high count", count_high(0, 100), 20);
    check("ovf last high",  last_high(100),     80);
    check("ovf gap",        int'(win_h[58]),    0);
    check("ovf win2 start", int'(win_h[59]),    1);
    check("ovf late_err",   int'(late_h[100]),  1);
`endif

    // Overlapping windows: triggers at 0 and 2, width 10
    do_reset();
    set_cfg(0, 10, "ovl");
    clear_waves();
    trig_w[0] = 1'b1;
    trig_w[2] = 1'b1;
    run(40);
    check("ovl start",   first_high(),    3);
    check("ovl w12",     int'(win_h[12]), 1);
`ifdef PULSE_WIN_SCHED_MERGE_EN
    check("ovl w14",        int'(win_h[14]),   1);
    check("ovl w15",        int'(win_h[15]),   0);
    check("ovl high count", count_high(0, 40), 12);
    check("ovl late_err",   int'(late_h[40]),  0);
`else
    check("ovl w13",        int'(win_h[13]),   0);
    check("ovl w14",        int'(win_h[14]),   0);
    check("ovl w15",        int'(win_h[15]),   1);
    check("ovl w24",        int'(win_h[24]),   1);
    check("ovl w25",        int'(win_h[25]),   0);
    check("ovl high count", count_high(0, 40), 20);
    check("ovl late_err",   int'(late_h[40]),  1);
`endif

    // Config write while a window is active and another is queued
    do_reset();
    set_cfg(5, 3, "cfg");
    clear_waves();
    trig_w[0]  = 1'b1;
    trig_w[2]  = 1'b1;
    wr_w[8]    = 1'b1;
    trig_w[30] = 1'b1;
    cfg_delay  = CW'(20);
    cfg_width  = CW'(3);
    run(70);
    check("cfg win1 start", first_high(),       8);
    check("cfg ack count",  count_ack(0, 70),   1);
`ifdef PULSE_WIN_SCHED_MERGE_EN
    check("cfg merged end", last_high(30),      12);
    check("cfg ack cycle",  int'(ack_h[14]),    1);
`else
    check("cfg win2 gap",   int'(win_h[12]),    0);
    check("cfg win2 start", int'(win_h[13]),    1);
    check("cfg win2 end",   last_high(30),      15);
    check("cfg ack cycle",  int'(ack_h[17]),    1);
`endif
    check("cfg new pre",    int'(win_h[52]),    0);
    check("cfg new start",  int'(win_h[53]),    1);
    check("cfg new end",    int'(win_h[55]),    1);
    check("cfg new after",  int'(win_h[56]),    0);
    check("cfg new count",  count_high(31, 70), 3);

    // Reset mid-window with queued triggers
    do_reset();
    set_cfg(10, 20, "rst");
    clear_waves();
    trig_w[0]  = 1'b1;
    trig_w[2]  = 1'b1;
    trig_w[4]  = 1'b1;
    rst_w[15]  = 1'b1;
    trig_w[20] = 1'b1;
    run(60);
    check("rst active before", int'(win_h[15]), 1);
`ifdef PULSE_WIN_SCHED_MERGE_EN
    check("rst pend before", pend_h[15], 0);
`else
    check("rst pend before", pend_h[15], 2);
`endif
    check("rst win_out",    int'(win_h[16]),   0);
    check("rst pend_cnt",   pend_h[16],        0);
    check("rst busy",       int'(busy_h[16]),  0);
    check("rst ovf_err",    int'(ovf_h[16]),   0);
    check("rst late_err",   int'(late_h[16]),  0);
    check("rst new start",  int'(win_h[23]),   1);
    check("rst new width",  count_high(16, 60), 1);
    check("rst no ack",     count_ack(16, 60), 0);
    check("rst late final", int'(late_h[60]),  0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pulse_window_sched.md
Name: pulse_window_sched

Overview:
- Trigger-driven window scheduler for the pulse datapath. Each rising edge on trig_in is timestamped and queued.
- For every queued trigger, one gate window of programmable delay and width is produced, in order.
- The block sequences pending triggers through a single window engine. It is the controller in front of pulse extend/delay stages when triggers arrive faster than windows complete.

Parameters:
DEPTH, 4, pending-trigger FIFO entries (power of 2, >=2)
CW, 32, timestamp/config counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
trig_in  input  1  trigger; each rising edge = one trigger
cfg_delay  input  CW  window delay, cycles
cfg_width  input  CW  window width, cycles (0 treated as 1)
cfg_wr  input  1  load cfg_delay/cfg_width into shadow
cfg_ack  output  1  1-cycle pulse: shadow applied to active config
win_out  output  1  gate window out
busy  output  1  FSM not IDLE or FIFO non-empty
pend_cnt  output  $clog2(DEPTH)+1  FIFO occupancy
ovf_err  output  1  sticky: trigger dropped, FIFO full
late_err  output  1  sticky: window started after nominal start

Behaviour:
- Interface: one clock, clk; rst is synchronous, active-high. All outputs registered.
- Reset values: win_out=0, cfg_ack=0, busy=0, pend_cnt=0, ovf_err=0, late_err=0.
- Reset also sets: tcnt=0, FIFO empty, trig_prev=0, active delay=0, active width=1, shadow-pending flag clear.
- rst mid-window: win_out=0 from the next cycle; all queued triggers are discarded.
- tcnt: free-running CW-bit counter, +1 per cycle, wraps mod 2^CW.
- Elapsed/end compares use modular subtraction. The legal configuration range is delay+width+DEPTH*width < 2^(CW-1); behaviour outside it is undefined.
- Trigger detect: a trigger occurs at cycle t when trig_in=1 and trig_prev=0. tcnt(t) is pushed to the FIFO.
- Push to full FIFO with no pop in the same cycle: trigger dropped, ovf_err set.
- Simultaneous push and pop on a full FIFO is legal.
- Config update:
  - cfg_wr captures both inputs into the shadow; a later cfg_wr overwrites the shadow.
  - Shadow is applied on the first cycle with FSM=IDLE and FIFO empty; cfg_ack pulses the following cycle.
  - In-flight and queued windows use the config active when they are popped.
- FSM:
  - IDLE: FIFO non-empty -> pop head into ts_r, latch delay/width -> WAIT.
  - WAIT: once the nominal start is reached or passed -> ACTIVE.
    - Nominal start = ts_r + 3 + delay.
    - If the actual start is later than nominal, set late_err.
  - ACTIVE: win_out=1 for exactly width cycles, then -> IDLE.
- Latency: a trigger at cycle t with an idle engine gives win_out high from cycle t+3+delay through t+2+delay+width.
- Back-to-back windows (macro off): ACTIVE last cycle c -> earliest next win_out high is c+3. Minimum gap is 2 low cycles.
- pend_cnt updates the cycle after push/pop. busy asserts the cycle after the first trigger.

Optional Feature:
- Macro: PULSE_WIN_SCHED_MERGE_EN.
- Defined (during ACTIVE):
  - If the FIFO head's nominal start <= current window end + 1, pop the head and extend the current end to max(current end, head nominal end).
  - win_out stays high continuously; merged windows never set late_err.
  - Repeats for each further eligible head.
- Undefined: no merge logic; late overlapping windows are serialized per the back-to-back rule and set late_err.

Test Plan:
1. delay=10, width=5, cfg_wr, then trigger at t=100:
   - cfg_ack pulses once before the trigger.
   - win_out high cycles 113..117 only; pend_cnt 1 then 0; busy low from cycle 118 onward.
2. trig_in held high 20 cycles, delay=0, width=4 -> exactly one window, 4 cycles high; ovf_err=0.
3. DEPTH=4, delay=50, width=4, 6 rising edges spaced 2 cycles -> 5 windows in order, ovf_err=1, pend_cnt peaks at 4.
4. delay=0, width=10, triggers at t and t+2:
   - Macro off: window 1 at t+3..t+12, window 2 at t+15..t+24, late_err=1.
   - Macro on: single window t+3..t+14, late_err=0.
5. cfg_wr(delay=20) during an ACTIVE window with one trigger queued:
   - The queued window uses the old delay.
   - cfg_ack fires only after the engine is idle and the FIFO is empty.
   - The next trigger uses delay=20.
6. rst asserted for one cycle mid-ACTIVE with 2 triggers queued:
   - Next cycle: win_out=0, pend_cnt=0, errors=0, config at defaults.
   - A new trigger then yields a window at t+3 with width 1.
